// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART transmit controller
package uart_pkg;
   localparam int UART_DATA_W          = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 87;
   localparam int DEFAULT_FIFO_AW      = 3;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_DATA_W,
   parameter int AW    = DEFAULT_FIFO_AW
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);
   localparam int DEPTH = 2**AW;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // A push while full is refused even if a pop frees a slot this cycle.
   assign w_push  = wr_en && !full;
   assign w_pop   = rd_en && !empty;
   assign full    = (r_count == FULL_CNT);
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign rd_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - CPU-fed byte FIFO and 8N1 serializer driving uart_tx
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_AW      = DEFAULT_FIFO_AW
) (
   input  logic                   sysclk,
   input  logic                   cpu_resetn,
   input  logic                   wr_en,
   input  logic [UART_DATA_W-1:0] wr_data,
   input  logic                   ovf_clr,
   output logic                   ready,
   output logic                   busy,
   output logic                   overflow,
   output logic                   uart_tx
);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

   tx_state_t              r_state;
   logic [TW-1:0]          r_timer;
   logic [2:0]             r_bit_idx;
   logic [UART_DATA_W-1:0] r_shift;
   logic                   r_tx;
   logic                   r_overflow;

   logic [UART_DATA_W-1:0] w_head;
   logic                   w_full;
   logic                   w_empty;
   logic [FIFO_AW:0]       w_count;
   logic                   w_bit_end;
   logic                   w_pop;

   assign w_bit_end = (r_timer == T_LAST);
   // Popping at the end of STOP lets the next frame start with no idle gap.
   assign w_pop     = !w_empty && ((r_state == IDLE) || (r_state == STOP && w_bit_end));

   sync_fifo #(
      .WIDTH (UART_DATA_W),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk     (sysclk),
      .resetn  (cpu_resetn),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (w_pop),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   assign ready    = !w_full;
   assign busy     = (w_count != '0) || (r_state != IDLE);
   assign overflow = r_overflow;
   assign uart_tx  = r_tx;

   always_ff @(posedge sysclk) begin
      if (!cpu_resetn) begin
         r_state    <= IDLE;
         r_timer    <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
         r_tx       <= 1'b1;
         r_overflow <= 1'b0;
      end else begin
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end else if (ovf_clr) begin
            r_overflow <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               r_timer <= '0;
               r_tx    <= 1'b1;
               if (!w_empty) begin
                  r_shift <= w_head;
                  r_state <= START;
                  r_tx    <= 1'b0;
               end
            end
            START: begin
               if (w_bit_end) begin
                  r_timer   <= '0;
                  r_bit_idx <= '0;
                  r_state   <= DATA;
                  r_tx      <= r_shift[0];
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  r_timer <= '0;
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= STOP;
                     r_tx    <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_tx      <= r_shift[1];
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            STOP: begin
               if (w_bit_end) begin
                  r_timer <= '0;
                  if (!w_empty) begin
                     r_shift <= w_head;
                     r_state <= START;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= IDLE;
                     r_tx    <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl with a line decoder
module tb_uart_tx_ctrl;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       sysclk     = 1'b0;
   logic       cpu_resetn = 1'b0;
   logic       wr_en      = 1'b0;
   logic [7:0] wr_data    = 8'h00;
   logic       ovf_clr    = 1'b0;
   logic       ready;
   logic       busy;
   logic       overflow;
   logic       uart_tx;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   logic [7:0] exp_q[$];
   bit         contig_chk  = 1'b0;
   bit         contig_have = 1'b0;

   uart_tx_ctrl #(
      .CLKS_PER_BIT (CPB),
      .FIFO_AW      (3)
   ) dut (
      .sysclk     (sysclk),
      .cpu_resetn (cpu_resetn),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .ovf_clr    (ovf_clr),
      .ready      (ready),
      .busy       (busy),
      .overflow   (overflow),
      .uart_tx    (uart_tx)
   );

   always #5 sysclk = ~sysclk;
   always @(posedge sysclk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   // Line decoder: one sample per cycle, a frame is exactly FRAME samples.
   initial begin : monitor
      logic [FRAME-1:0] smp;
      int               sidx;
      bit               in_frame;
      int               start_cyc;
      int               prev_start;
      logic [7:0]       got;
      logic [7:0]       exp_b;
      bit               shape_ok;
      in_frame   = 1'b0;
      sidx       = 0;
      prev_start = 0;
      forever begin
         @(negedge sysclk);
         if (!cpu_resetn) begin
            in_frame    = 1'b0;
            contig_have = 1'b0;
         end else if (!in_frame) begin
            if (uart_tx === 1'b0) begin
               in_frame  = 1'b1;
               smp[0]    = 1'b0;
               sidx      = 1;
               start_cyc = cyc;
               if (contig_chk && contig_have) begin
                  n_vec++;
                  if (start_cyc - prev_start !== FRAME) begin
                     n_err++;
                     $display("FAIL frame_spacing: got %0d cycles, expected %0d", start_cyc - prev_start, FRAME);
                  end
               end
               prev_start  = start_cyc;
               contig_have = 1'b1;
            end
         end else begin
            smp[sidx] = uart_tx;
            sidx++;
            if (sidx == FRAME) begin
               in_frame = 1'b0;
               shape_ok = 1'b1;
               for (int b = 0; b < 10; b++)
                  for (int j = 0; j < CPB; j++)
                     if (smp[b*CPB+j] !== smp[b*CPB]) shape_ok = 1'b0;
               if (smp[0] !== 1'b0 || smp[FRAME-1] !== 1'b1) shape_ok = 1'b0;
               for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*CPB];
               n_vec++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL frame_unexpected: got %02h, expected no frame", got);
               end else begin
                  exp_b = exp_q.pop_front();
                  if (!shape_ok || got !== exp_b) begin
                     n_err++;
                     $display("FAIL frame_data: got %02h shape_ok=%0d, expected %02h shape_ok=1", got, shape_ok, exp_b);
                  end
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge sysclk);
      @(negedge sysclk);
   endtask

   task automatic write_byte(input logic [7:0] d, input bit push);
      wr_en   = 1'b1;
      wr_data = d;
      if (push) exp_q.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while ((busy !== 1'b0 || exp_q.size() != 0) && n < max_cyc) begin
         step();
         n++;
      end
      step();
      n_vec++;
      if (n >= max_cyc || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: busy=%0d pending=%0d after %0d cycles, required busy=0 pending=0", busy, exp_q.size(), n);
      end
   endtask

   task automatic test_reset();
      int bad;
      cpu_resetn = 1'b0;
      step();
      step();
      cpu_resetn = 1'b1;
      step();
      n_vec += 4;
      if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b, expected 1", uart_tx); end
      if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, expected 1", ready); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b, expected 0", overflow); end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (uart_tx !== 1'b1) bad++;
         step();
      end
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL idle_line: got %0d low cycles, expected 0", bad); end
   endtask

   task automatic test_single();
      int bad;
      write_byte(8'hA5, 1'b1);
      bad = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (busy !== 1'b1) bad++;
      end
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL single_busy_hold: got %0d low cycles, expected 0", bad); end
      step();
      n_vec += 2;
      if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b, expected 0", busy); end
      if (exp_q.size() != 0) begin n_err++; $display("FAIL single_frame: got %0d pending, expected 0", exp_q.size()); end
   endtask

   task automatic test_fill_overflow();
      contig_have = 1'b0;
      contig_chk  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (ready !== (i < 9)) begin
            n_err++;
            $display("FAIL fill_ready[%0d]: got %b, expected %b", i, ready, (i < 9));
         end
         write_byte(8'(i), i < 9);
      end
      n_vec += 2;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf: got %b, expected 1", overflow); end
      if (ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_low: got %b, expected 0", ready); end
      wait_drain(450);
      contig_chk = 1'b0;
   endtask

   task automatic test_ovf_clr();
      n_vec++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_before_clr: got %b, expected 1", overflow); end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      n_vec++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b, expected 0", overflow); end
      for (int i = 0; i < 9; i++) write_byte(8'h10 + 8'(i), 1'b1);
      n_vec++;
      if (ready !== 1'b0) begin n_err++; $display("FAIL ovf_full: got ready %b, expected 0", ready); end
      ovf_clr = 1'b1;
      write_byte(8'hEE, 1'b0);
      ovf_clr = 1'b0;
      n_vec++;
      if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b, expected 1", overflow); end
      wait_drain(450);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
   endtask

   task automatic test_reset_midframe();
      write_byte(8'h3C, 1'b1);
      write_byte(8'h55, 1'b1);
      repeat (17) step();
      cpu_resetn = 1'b0;
      step();
      n_vec += 4;
      if (uart_tx !== 1'b1) begin n_err++; $display("FAIL midreset_tx: got %b, expected 1", uart_tx); end
      if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b, expected 0", busy); end
      if (ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b, expected 1", ready); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL midreset_ovf: got %b, expected 0", overflow); end
      exp_q.delete();
      step();
      cpu_resetn = 1'b1;
      step();
      write_byte(8'h81, 1'b1);
      wait_drain(100);
      repeat (20) step();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 16; i++) begin
         write_byte(8'($urandom), 1'b1);
         repeat (39) step();
      end
      n_vec++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL stream_ovf: got %b, expected 0", overflow); end
      wait_drain(200);
   endtask

   initial begin
      @(negedge sysclk);
      test_reset();
      test_single();
      test_fill_overflow();
      test_ovf_clr();
      test_reset_midframe();
      test_stream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
